// File: rtl/branch_unit_if.sv
// Bus between execute/fetch and the branch unit.
// master: execute + fetch side (drives resolutions and fetch_ready).
// slave : branch_unit (owns the fetch PC, flush and link outputs).
interface branch_unit_if #(
  parameter int data_size  = 16,
  parameter int addr_size  = 16,
  parameter int count_size = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            kind;
  logic [data_size-1:0]  cond;
  logic [addr_size-1:0]  in_pc;
  logic [addr_size-1:0]  target;
  logic [addr_size-1:0]  pc_out;
  logic                  pc_valid;
  logic                  fetch_ready;
  logic                  redirect;
  logic                  link_valid;
  logic [addr_size-1:0]  link_value;
  logic [count_size-1:0] taken_count;

  modport master (
    output in_valid, kind, cond, in_pc, target, fetch_ready,
    input  in_ready, pc_out, pc_valid, redirect, link_valid, link_value, taken_count
  );

  modport slave (
    input  in_valid, kind, cond, in_pc, target, fetch_ready,
    output in_ready, pc_out, pc_valid, redirect, link_valid, link_value, taken_count
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution and fetch PC sequencer.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - branch_unit_if.slave: resolution input (in_valid/in_ready, kind,
//            cond, in_pc, target), fetch request (pc_out, pc_valid,
//            fetch_ready), flush/link pulses and taken-transfer counter.
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch, no resolutions
// RUN   | fetching sequentially, accepting resolutions
// FLUSH | one bubble after a taken transfer; resolutions ignored
module branch_unit #(
  parameter int          data_size    = 16,
  parameter int          addr_size    = 16,
  parameter int unsigned reset_vector = 0,
  parameter int          count_size   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_unit_if.slave     bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [addr_size-1:0] RV = addr_size'(reset_vector);

  logic [1:0]            state_q, state_d;
  logic [addr_size-1:0]  pc_q, pc_d;
  logic                  redirect_q, redirect_d;
  logic                  link_valid_q, link_valid_d;
  logic [addr_size-1:0]  link_value_q, link_value_d;
  logic [count_size-1:0] count_q, count_d;

  logic run;
  logic fetch_hs;
  logic res_hs;
  logic taken;

  // Only the comparator's bit 0 carries meaning.
  logic unused_cond;
  assign unused_cond = ^bus.cond[data_size-1:1];

  assign run      = (state_q == RUN);
  assign fetch_hs = run && bus.fetch_ready;
  assign res_hs   = run && bus.in_valid;
  assign taken    = res_hs && (bus.kind[1] || (bus.kind == 2'b01 && bus.cond[0]));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirect_d   = 1'b0;
    link_valid_d = 1'b0;
    link_value_d = link_value_q;
    count_d      = count_q;
    case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        // A taken transfer overrides the sequential increment.
        if (taken) begin
          state_d    = FLUSH;
          pc_d       = bus.target;
          redirect_d = 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (bus.kind == 2'b11) begin
            link_valid_d = 1'b1;
            link_value_d = bus.in_pc + 1'b1;
          end
        end else if (fetch_hs) begin
          pc_d = pc_q + 1'b1;
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RV;
      redirect_q   <= 1'b0;
      link_valid_q <= 1'b0;
      link_value_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      link_valid_q <= link_valid_d;
      link_value_q <= link_value_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready    = run;
  assign bus.pc_valid    = run;
  assign bus.pc_out      = pc_q;
  assign bus.redirect    = redirect_q;
  assign bus.link_valid  = link_valid_q;
  assign bus.link_value  = link_value_q;
  assign bus.taken_count = count_q;

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch resolution and program-counter sequencer for the CPU core. Consumes the 1-bit condition produced by the comparator (zero-extended to `data_size`), decides taken/not-taken for conditional and unconditional control transfers, and owns the fetch PC register. Issues a one-cycle flush pulse and a link value on taken transfers. Sits between execute (comparator output) and the fetch stage.

## Interface
- `data_size`, 16, width of the condition word from the comparator
- `addr_size`, 16, PC width, word-addressed
- `reset_vector`, 0, first fetch address after reset
- `count_size`, 16, width of the taken-branch counter

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  execute presents a control-transfer resolution
- `in_ready`  out  1  unit accepts a resolution this cycle
- `kind`  in  2  00 none, 01 conditional, 10 jump, 11 jump-and-link
- `cond`  in  data_size  comparator result; only bit 0 used, other bits ignored
- `in_pc`  in  addr_size  PC of the resolving instruction
- `target`  in  addr_size  destination address
- `pc_out`  out  addr_size  current fetch address
- `pc_valid`  out  1  fetch request valid
- `fetch_ready`  in  1  fetch stage accepts `pc_out`
- `redirect`  out  1  one-cycle flush pulse to younger pipeline stages
- `link_valid`  out  1  one-cycle pulse, `link_value` is valid
- `link_value`  out  addr_size  return address for jump-and-link
- `taken_count`  out  count_size  saturating count of taken transfers

## Operation
- States: BOOT, RUN, FLUSH. Reset enters BOOT.
- BOOT: `pc_valid`=0, `in_ready`=0; unconditionally to RUN next cycle.
- RUN: `pc_valid`=1, `in_ready`=1.
  - Fetch handshake (`pc_valid && fetch_ready`): `pc_out` <= `pc_out`+1, modulo 2^addr_size (0xFFFF wraps to 0x0000).
  - Resolution handshake (`in_valid && in_ready`): taken = (kind==10) | (kind==11) | (kind==01 & cond[0]). kind==00 and not-taken conditionals have no effect.
  - Taken: `pc_out` <= `target`, `redirect` <= 1, state -> FLUSH, `taken_count` += 1 (saturates at all-ones, no wrap).
  - kind==11 additionally: `link_value` <= `in_pc`+1 (modulo 2^addr_size), `link_valid` <= 1.
  - Taken resolution and fetch handshake in the same cycle: redirect wins, increment discarded.
- FLUSH: `pc_valid`=0, `in_ready`=0, `in_valid` ignored; to RUN next cycle.
- `redirect` and `link_valid` are registered, high for exactly one cycle, never in consecutive cycles.
- `link_value` holds its last value until the next jump-and-link.
- `fetch_ready` low in RUN: `pc_out` holds; resolutions still accepted.

## Timing
- Reset values (asserted immediately, asynchronously): `pc_out`=`reset_vector`, `pc_valid`=0, `in_ready`=0, `redirect`=0, `link_valid`=0, `link_value`=0, `taken_count`=0, state BOOT.
- Reset asserted mid-operation: in-flight redirect or link pulse is dropped; restart from BOOT.
- First fetch request: second rising edge after `rst_n` deasserts (BOOT for one cycle, then RUN).
- Taken handshake at edge N: after edge N `redirect`=1, `pc_out`=`target`, `pc_valid`=0 (FLUSH); after edge N+1 `redirect`=0, `pc_valid`=1, `pc_out`=`target`. Target fetch latency: 2 cycles.
- Not-taken resolution: zero latency impact; `pc_out` behaves as if no resolution occurred.
- `in_ready` is a function of state only, never of `in_valid`.

## Test plan
- Reset release, `fetch_ready`=1, no resolutions -> `pc_valid` rises one cycle after release; `pc_out` 0x0000, 0x0001, 0x0002 on consecutive cycles.
- kind=01, cond=0x0001, target=0x0040, coincident fetch handshake -> `redirect` one-cycle pulse, one cycle `pc_valid`=0, then `pc_out`=0x0040; `taken_count`=1.
- kind=01, cond=0xFFFE (bit 0 clear), target=0x0040 -> no redirect, `pc_out` increments normally, `taken_count` unchanged.
- kind=11, in_pc=0xFFFF, target=0x1234 -> `link_valid` pulse with `link_value`=0x0000, `pc_out`=0x1234 two cycles later; `in_valid` held high during FLUSH is not accepted.
- `pc_out`=0xFFFF with fetch handshake -> `pc_out`=0x0000; `fetch_ready`=0 for 3 cycles -> `pc_out` stable.
- `taken_count` preset via 2^count_size taken jumps (count_size=4) -> counter stops at 0xF; `rst_n` pulsed low during FLUSH -> all outputs at reset values immediately, BOOT then RUN from `reset_vector`.
